// File: rtl/conv_stream_pkg.sv
// Shared types for the vector streaming blocks: FSM state encoding and default word width.
package conv_stream_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int WORD_W_DEFAULT = 11;

endpackage

// File: rtl/vector_stream_src_vec_ram.sv
// Single-port W x N vector store with synchronous read; contents are never reset.
module vec_ram #(
  parameter int N  = 30,
  parameter int W  = 11,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vector_stream_src.sv
// Loads an N-word signed vector, then replays it REPS times as a valid/ready stream.
//   state | meaning
//   LOAD  | accepting load words into vec_ram at wr_ptr
//   FETCH | first RAM read of word 0 in flight
//   SEND  | streaming; RAM output register feeds the out_data register
//   DRAIN | one idle cycle after the final word before reloading
module vector_stream_src
  import conv_stream_pkg::*;
#(
  parameter int N    = 30,
  parameter int W    = WORD_W_DEFAULT,
  parameter int REPS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                done
);

  localparam int PW = $clog2(N);
  localparam int RW = $clog2(REPS + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPS - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr, ptr_inc, ram_addr;
  logic [RW-1:0] rep_cnt, rep_inc;
  logic [W-1:0]  ram_rdata;
  logic          ram_we, ram_vld, ram_last, out_last;
  logic          hs_out, adv, fetch_nxt;

  assign in_ready  = (state == LOAD);
  assign ram_we    = in_ready && in_valid;
  assign hs_out    = out_valid && out_ready;
  assign adv       = !out_valid || out_ready;
  assign done      = hs_out && out_last;
  // ram_rdata holds word rd_ptr; step the address only when the output stage takes it
  assign fetch_nxt = (state == SEND) && adv && ram_vld && !ram_last;

  always_comb begin
    ptr_inc = rd_ptr + 1'b1;
    rep_inc = rep_cnt;
    if (rd_ptr == PTR_LAST) begin
      ptr_inc = '0;
      rep_inc = rep_cnt + 1'b1;
    end
  end

  always_comb begin
    ram_addr = '0;
    case (state)
      LOAD:    ram_addr = wr_ptr;
      FETCH:   ram_addr = rd_ptr;
      SEND:    ram_addr = fetch_nxt ? ptr_inc : rd_ptr;
      default: ram_addr = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (ram_we && wr_ptr == PTR_LAST) state_nxt = FETCH;
      FETCH:   state_nxt = SEND;
      SEND:    if (done) state_nxt = DRAIN;
      DRAIN:   state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rep_cnt   <= '0;
      ram_vld   <= 1'b0;
      ram_last  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ram_we) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      case (state)
        FETCH: begin
          rd_ptr   <= '0;
          rep_cnt  <= '0;
          ram_vld  <= 1'b1;
          ram_last <= 1'b0;
        end
        SEND: begin
          if (adv) begin
            out_valid <= ram_vld;
            out_last  <= ram_vld && ram_last;
            if (ram_vld) out_data <= ram_rdata;
          end
          if (adv && ram_vld) begin
            if (ram_last) begin
              ram_vld <= 1'b0;
            end else begin
              rd_ptr   <= ptr_inc;
              rep_cnt  <= rep_inc;
              ram_last <= (ptr_inc == PTR_LAST) && (rep_inc == REP_LAST);
            end
          end
        end
        DRAIN: begin
          rd_ptr    <= '0;
          rep_cnt   <= '0;
          ram_vld   <= 1'b0;
          ram_last  <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  vec_ram #(.N(N), .W(W), .AW(PW)) u_vec_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (in_data),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_vector_stream_src.sv
// Scoreboard bench: loads vectors, expects each replayed REPS times in order, one done per stream.
module tb_vector_stream_src;

  localparam int N    = 30;
  localparam int W    = 11;
  localparam int REPS = 3;

  typedef struct {
    logic signed [W-1:0] d;
    bit                  last;
  } exp_t;

  logic                clk;
  logic                reset;
  logic signed [W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                done;

  exp_t exp_q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   hs_cnt = 0;
  int   rdy_mode = 0;
  bit   prev_stall = 0;
  logic signed [W-1:0] prev_data;
  logic signed [W-1:0] vec [N];

  vector_stream_src #(.N(N), .W(W), .REPS(REPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // out_ready patterns: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1
  initial begin
    int ph;
    ph = 0;
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       out_ready = 1'($urandom_range(1));
        2: begin
          out_ready = (ph == 0 || ph == 3);
          ph = (ph + 1) % 4;
        end
        default: out_ready = 1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(prev_data));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word got %0d expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("data", int'(out_data), int'(e.d));
          check("done", int'(done), int'(e.last));
        end
      end else begin
        check("done_idle", int'(done), 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Loads the first cnt words of v; only a complete vector produces expected output.
  task automatic load_vec(input logic signed [W-1:0] v [N], input int cnt,
                          input int gap_pct, input bit keep_77);
    int k, guard;
    bit hs;
    k = 0;
    guard = 0;
    while (k < cnt && guard < 2000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = v[k];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    check("load_complete", k, cnt);
    if (keep_77) begin
      in_valid = 1;
      in_data  = 11'sd77;
    end else begin
      in_valid = 0;
    end
    if (cnt == N)
      for (int r = 0; r < REPS; r++)
        for (int i = 0; i < N; i++)
          exp_q.push_back('{d: v[i], last: (r == REPS - 1 && i == N - 1)});
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(exp_q.size() == 0 && in_ready) && c < 4000);
    check("stream_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    exp_q.delete();
  endtask

  initial begin
    int cnt, c;
    bit seen;
    reset    = 1;
    in_valid = 0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_done", int'(done), 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // ramp 0..29, continuous load, always ready: latency, gapless replay, in_ready return
    rdy_mode = 0;
    for (int i = 0; i < N; i++) vec[i] = W'(i);
    load_vec(vec, N, 0, 0);
    @(negedge clk);
    check("lat_fetch_valid", int'(out_valid), 0);
    check("busy_in_ready", int'(in_ready), 0);
    @(negedge clk);
    check("lat_edge1_valid", int'(out_valid), 0);
    @(negedge clk);
    check("lat_edge2_valid", int'(out_valid), 1);
    cnt = 0;
    seen = 0;
    for (c = 0; c < 400 && !seen; c++) begin
      cnt++;
      if (done) seen = 1;
      else @(negedge clk);
    end
    check("gapless_len", cnt, N * REPS);
    @(negedge clk);
    check("drain_in_ready", int'(in_ready), 0);
    check("drain_out_valid", int'(out_valid), 0);
    @(negedge clk);
    check("reload_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    check("ramp_drained", exp_q.size(), 0);

    // backpressure 1,0,0,1 with extreme values
    rdy_mode = 2;
    vec[0] = -11'sd1024;
    vec[1] = 11'sd1023;
    vec[2] = 11'sd5;
    for (int i = 3; i < N; i++) vec[i] = W'($urandom_range(0, (1 << W) - 1));
    load_vec(vec, N, 0, 0);
    wait_idle();

    // random vectors, random load gaps and random backpressure
    rdy_mode = 1;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) vec[i] = W'($urandom_range(0, (1 << W) - 1));
      load_vec(vec, N, 30, 0);
      wait_idle();
    end

    // reset after 12 load words, then a fresh 100..129 vector
    rdy_mode = 0;
    for (int i = 0; i < N; i++) vec[i] = W'(-i - 1);
    load_vec(vec, 12, 0, 0);
    pulse_reset();
    @(negedge clk);
    check("midload_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) vec[i] = W'(100 + i);
    load_vec(vec, N, 0, 0);
    wait_idle();

    // reset during the stream around word 17, then a new load from address 0
    rdy_mode = 0;
    for (int i = 0; i < N; i++) vec[i] = W'(500 + i);
    load_vec(vec, N, 0, 0);
    hs_cnt = 0;
    c = 0;
    while (hs_cnt < 17 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("reach_word17", int'(hs_cnt >= 17), 1);
    @(posedge clk); #1;
    pulse_reset();
    @(negedge clk);
    check("midstream_out_valid", int'(out_valid), 0);
    check("midstream_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) vec[i] = W'(-300 + 7 * i);
    rdy_mode = 1;
    load_vec(vec, N, 10, 0);
    wait_idle();

    // in_valid held with 77 through the whole stream must not alter RAM
    rdy_mode = 1;
    for (int i = 0; i < N; i++) vec[i] = W'(200 - 13 * i);
    load_vec(vec, N, 0, 1);
    seen = 0;
    for (c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("hold77_done_seen", int'(seen), 1);
    @(posedge clk); #1;
    in_valid = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
